// File: rtl/charge_grid_banks_if.sv
`default_nettype none
// ============================================================================
// Module   : charge_grid_banks_if
// Brief    : Bundle of the 4-corner read/write ports, clear/dump controls and
//            the dump stream of the banked charge grid.
// Revision : 1.0 - initial release
// ============================================================================
interface charge_grid_banks_if #(
  parameter int ADDR_W   = 16,
  parameter int CHARGE_W = 24
);
  logic                  rd_valid;
  logic [4*ADDR_W-1:0]   rd_addr;
  logic [4*CHARGE_W-1:0] rd_charge;
  logic [4*ADDR_W-1:0]   rd_addr_echo;
  logic                  wr_valid;
  logic [4*ADDR_W-1:0]   wr_addr;
  logic [4*CHARGE_W-1:0] wr_charge;
  logic                  start_clear;
  logic                  start_dump;
  logic                  busy;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [ADDR_W-1:0]     dump_addr;
  logic [CHARGE_W-1:0]   dump_charge;
  logic                  err_access;

  // Accumulator / field-solver side
  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_charge,
           start_clear, start_dump, dump_ready,
    input  rd_charge, rd_addr_echo, busy, dump_valid, dump_addr,
           dump_charge, err_access
  );

  // Grid storage side
  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_charge,
           start_clear, start_dump, dump_ready,
    output rd_charge, rd_addr_echo, busy, dump_valid, dump_addr,
           dump_charge, err_access
  );
endinterface
`default_nettype wire

// File: rtl/charge_grid_banks.sv
`default_nettype none
// ============================================================================
// Module   : charge_grid_banks
// Brief    : Charge grid split into 4 parity-interleaved banks so each corner
//            of a cell hits its own bank; one 4-corner read and one 4-corner
//            write per cycle, plus whole-grid CLEAR and backpressured DUMP.
//            Optional macro DUMP_CLEAR_EN: DUMP zeroes every cell it reads.
//            READ_LAT must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module charge_grid_banks #(
  parameter int GX_BITS  = 8,
  parameter int GY_BITS  = 8,
  parameter int CHARGE_W = 24,
  parameter int READ_LAT = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  charge_grid_banks_if.slave bus
);
  localparam int ADDR_W     = GY_BITS + GX_BITS;
  localparam int BANK_AW    = ADDR_W - 2;
  localparam int BANK_DEPTH = 2 ** BANK_AW;
  localparam int FIFO_DEPTH = READ_LAT + 1;
  localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [BANK_AW-1:0] c_last_baddr = {BANK_AW{1'b1}};
  localparam logic [ADDR_W-1:0]  c_last_cell  = {ADDR_W{1'b1}};

  // IDLE doubles as the scatter-ready state.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_DUMP = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  function automatic logic [1:0] f_bank(input logic [ADDR_W-1:0] a);
    return {a[GX_BITS], a[0]};
  endfunction

  function automatic logic [BANK_AW-1:0] f_baddr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:GX_BITS+1], a[GX_BITS-1:1]};
  endfunction

  function automatic logic [FIFO_PW-1:0] f_ptr_inc(input logic [FIFO_PW-1:0] p);
    return (p == FIFO_PW'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PW'(1);
  endfunction

  logic                  w_rd_ok, w_wr_ok, w_dump_issue, w_credit_ok, w_pop, w_push;
  logic [ADDR_W-1:0]     w_dump_lin;
  logic [CNT_W:0]        w_used;
  logic [BANK_AW-1:0]    w_raddr [4];
  logic [BANK_AW-1:0]    w_waddr [4];
  logic [CHARGE_W-1:0]   w_wdata [4];
  logic [3:0]            w_we;
  logic [CHARGE_W-1:0]   w_bank_q [4];
  logic [4*CHARGE_W-1:0] w_unswap;

  logic [BANK_AW-1:0]    r_clr_addr;
  logic [ADDR_W:0]       r_issue_cnt;
  logic                  r_ram_dv;
  logic [ADDR_W-1:0]     r_ram_dlin;
  logic [7:0]            r_ram_cbank;
  logic [READ_LAT-2:0]   r_v;
  logic [4*ADDR_W-1:0]   r_ram_addr;
  logic [4*CHARGE_W-1:0] r_pd [READ_LAT-1];
  logic [4*ADDR_W-1:0]   r_pa [READ_LAT-1];
  logic [CHARGE_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
  logic [FIFO_PW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;

  assign w_rd_ok      = (r_state == S_IDLE) && bus.rd_valid;
  assign w_wr_ok      = (r_state == S_IDLE) && bus.wr_valid;
  assign w_used       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_ram_dv};
  assign w_credit_ok  = w_used < (CNT_W+1)'(FIFO_DEPTH);
  assign w_dump_issue = (r_state == S_DUMP) && !r_issue_cnt[ADDR_W] && w_credit_ok;
  assign w_dump_lin   = r_issue_cnt[ADDR_W-1:0];
  assign w_pop        = bus.dump_valid && bus.dump_ready;
  assign w_push       = r_ram_dv;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: CLEAR beats DUMP; start pulses outside IDLE are dropped
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_clear)     w_state_nxt = S_CLEAR;
        else if (bus.start_dump) w_state_nxt = S_DUMP;
      end
      S_CLEAR: if (r_clr_addr == c_last_baddr) w_state_nxt = S_IDLE;
      S_DUMP:  if (w_pop && bus.dump_addr == c_last_cell) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Route corners, clear sweep and dump reads onto the four bank ports
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_raddr[b] = '0;
      w_waddr[b] = (r_state == S_CLEAR) ? r_clr_addr : '0;
      w_wdata[b] = '0;
    end
    w_we = (r_state == S_CLEAR) ? 4'hF : 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (w_rd_ok)
        w_raddr[f_bank(bus.rd_addr[i*ADDR_W +: ADDR_W])] = f_baddr(bus.rd_addr[i*ADDR_W +: ADDR_W]);
      if (w_wr_ok) begin
        w_we   [f_bank(bus.wr_addr[i*ADDR_W +: ADDR_W])] = 1'b1;
        w_waddr[f_bank(bus.wr_addr[i*ADDR_W +: ADDR_W])] = f_baddr(bus.wr_addr[i*ADDR_W +: ADDR_W]);
        w_wdata[f_bank(bus.wr_addr[i*ADDR_W +: ADDR_W])] = bus.wr_charge[i*CHARGE_W +: CHARGE_W];
      end
    end
    if (w_dump_issue) w_raddr[f_bank(w_dump_lin)] = f_baddr(w_dump_lin);
`ifdef DUMP_CLEAR_EN
    if (r_ram_dv) begin
      w_we   [f_bank(r_ram_dlin)] = 1'b1;
      w_waddr[f_bank(r_ram_dlin)] = f_baddr(r_ram_dlin);
      w_wdata[f_bank(r_ram_dlin)] = '0;
    end
`endif
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [CHARGE_W-1:0] r_mem [BANK_DEPTH];
    logic [CHARGE_W-1:0] r_q;
    // Read-first bank RAM: a same-address write is seen only by later reads
    always_ff @(posedge clk) begin
      r_q <= r_mem[w_raddr[b]];
      if (w_we[b]) r_mem[w_waddr[b]] <= w_wdata[b];
    end
    assign w_bank_q[b] = r_q;
  end

  // Clear sweep address and dump issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_addr  <= '0;
      r_issue_cnt <= '0;
    end else begin
      r_clr_addr  <= (r_state == S_CLEAR) ? r_clr_addr + BANK_AW'(1) : '0;
      if (r_state != S_DUMP) r_issue_cnt <= '0;
      else if (w_dump_issue) r_issue_cnt <= r_issue_cnt + (ADDR_W+1)'(1);
    end
  end

  // Side info travelling alongside the 1-cycle bank read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_dv    <= 1'b0;
      r_ram_dlin  <= '0;
      r_ram_cbank <= '0;
      r_ram_addr  <= '0;
    end else begin
      r_ram_dv    <= w_dump_issue;
      r_ram_dlin  <= w_dump_lin;
      r_ram_addr  <= bus.rd_addr;
      for (int i = 0; i < 4; i++) r_ram_cbank[i*2 +: 2] <= f_bank(bus.rd_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  // Put bank outputs back into corner order
  always_comb begin
    w_unswap = '0;
    for (int i = 0; i < 4; i++)
      w_unswap[i*CHARGE_W +: CHARGE_W] = w_bank_q[r_ram_cbank[i*2 +: 2]];
  end

  // Latency pipeline; each stage loads only for a live read so rd_charge holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < READ_LAT-1; k++) begin
        r_pd[k] <= '0;
        r_pa[k] <= '0;
      end
    end else begin
      r_v[0] <= w_rd_ok;
      if (r_v[0]) begin
        r_pd[0] <= w_unswap;
        r_pa[0] <= r_ram_addr;
      end
      for (int k = 1; k < READ_LAT-1; k++) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k]) begin
          r_pd[k] <= r_pd[k-1];
          r_pa[k] <= r_pa[k-1];
        end
      end
    end
  end

  // Dump output FIFO; credits guarantee a push always finds a free slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_fifo_data[k] <= '0;
        r_fifo_addr[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_bank_q[f_bank(r_ram_dlin)];
        r_fifo_addr[r_wptr] <= r_ram_dlin;
        r_wptr              <= f_ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= f_ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for scatter traffic arriving while the grid is busy
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (r_state != S_IDLE && (bus.rd_valid || bus.wr_valid)) r_err <= 1'b1;
  end

  assign bus.rd_charge    = r_pd[READ_LAT-2];
  assign bus.rd_addr_echo = r_pa[READ_LAT-2];
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.dump_valid   = (r_count != '0);
  assign bus.dump_addr    = r_fifo_addr[r_rptr];
  assign bus.dump_charge  = r_fifo_data[r_rptr];
  assign bus.err_access   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_charge_grid_banks.sv
`default_nettype none
// ============================================================================
// Module   : tb_charge_grid_banks
// Brief    : Self-checking bench for charge_grid_banks on a 16x16 grid with a
//            cell-level grid model, random scatter traffic and random dump
//            backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_charge_grid_banks;
  localparam int GX = 4, GY = 4, CW = 24, RL = 4, AW = 8, NCELL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  charge_grid_banks_if #(.ADDR_W(AW), .CHARGE_W(CW)) bus ();
  charge_grid_banks #(.GX_BITS(GX), .GY_BITS(GY), .CHARGE_W(CW), .READ_LAT(RL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- grid model ----------------
  typedef struct {
    int                 due;
    logic [4*CW-1:0]    data;
    logic [4*AW-1:0]    addr;
  } rd_t;

  int unsigned     mem [NCELL];
  rd_t             rq [$];
  logic [4*CW-1:0] exp_rd   = '0;
  logic [4*AW-1:0] exp_echo = '0;
  int              cyc = 0;
  int              m_state = 0;   // 0 idle, 1 clearing, 2 dumping
  int              clr_left = 0;
  bit              m_err = 1'b0;
  int              dump_seen = 0;
  bit              chk_en = 1'b0;

  // Model advances on every clock edge from the inputs sampled there
  always @(posedge clk) begin
    rd_t r;
    cyc++;
    if (rst) begin
      m_state = 0;
      m_err   = 1'b0;
      rq.delete();
      exp_rd   = '0;
      exp_echo = '0;
    end else begin
      if (m_state != 0 && (bus.rd_valid || bus.wr_valid)) m_err = 1'b1;
      case (m_state)
        0: begin
          if (bus.rd_valid) begin
            r.due  = cyc + RL - 1;
            r.addr = bus.rd_addr;
            for (int i = 0; i < 4; i++) begin
              r.data[i*CW +: CW] = CW'(mem[bus.rd_addr[i*AW +: AW]]);
              for (int j = i + 1; j < 4; j++)
                assert ({bus.rd_addr[i*AW+GX], bus.rd_addr[i*AW]} != {bus.rd_addr[j*AW+GX], bus.rd_addr[j*AW]})
                  else $error("illegal request: corners %0d and %0d share a bank", i, j);
            end
            rq.push_back(r);
          end
          if (bus.wr_valid)
            for (int i = 0; i < 4; i++) mem[bus.wr_addr[i*AW +: AW]] = bus.wr_charge[i*CW +: CW];
          if (bus.start_clear) begin
            m_state  = 1;
            clr_left = NCELL / 4;
          end else if (bus.start_dump) begin
            m_state   = 2;
            dump_seen = 0;
          end
        end
        1: begin
          clr_left--;
          if (clr_left == 0) begin
            foreach (mem[k]) mem[k] = 0;
            m_state = 0;
          end
        end
        default: begin
          if (dump_seen == NCELL) begin
            m_state = 0;
`ifdef DUMP_CLEAR_EN
            foreach (mem[k]) mem[k] = 0;
`endif
          end
        end
      endcase
    end
  end

  // Compare DUT outputs against the model mid-cycle
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rd   = rq[0].data;
        exp_echo = rq[0].addr;
        void'(rq.pop_front());
      end
      check("rd_charge", bus.rd_charge, exp_rd);
      check("rd_addr_echo", bus.rd_addr_echo, exp_echo);
      check("busy", bus.busy, m_state != 0);
      check("err_access", bus.err_access, m_err);
      if (m_state != 2) check("dump_valid_idle", bus.dump_valid, 1'b0);
      else if (bus.dump_valid && bus.dump_ready && dump_seen < NCELL) begin
        check("dump_addr", bus.dump_addr, dump_seen[AW-1:0]);
        check("dump_charge", bus.dump_charge, mem[dump_seen]);
        dump_seen++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [4*AW-1:0] corners(input int y, input int x);
    logic [4*AW-1:0] c;
    for (int i = 0; i < 4; i++)
      c[i*AW +: AW] = AW'((((y + i / 2) & 15) << GX) | ((x + i % 2) & 15));
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int y, input int x, input logic [4*CW-1:0] d);
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = corners(y, x);
    bus.wr_charge = d;
    tick();
    bus.wr_valid  = 1'b0;
  endtask

  task automatic do_read(input int y, input int x);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = corners(y, x);
    tick();
    bus.rd_valid = 1'b0;
  endtask

  // Cell n gets n+100, written through corner quads of even cells
  task automatic fill_grid();
    logic [4*AW-1:0] a;
    logic [4*CW-1:0] d;
    for (int y = 0; y < 16; y += 2)
      for (int x = 0; x < 16; x += 2) begin
        a = corners(y, x);
        for (int i = 0; i < 4; i++) d[i*CW +: CW] = CW'(a[i*AW +: AW]) + CW'(100);
        do_write(y, x, d);
      end
  endtask

  task automatic pulse_dump();
    bus.start_dump = 1'b1;
    tick();
    bus.start_dump = 1'b0;
  endtask

  task automatic wait_dump_done(input bit rand_ready);
    int n = 0;
    while (bus.busy && n < 5000) begin
      bus.dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    bus.dump_ready = 1'b0;
    check("dump_finished_in_budget", n < 5000, 1'b1);
    check("dump_word_count", dump_seen, NCELL);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_charge = '0;
    bus.start_clear = 1'b0; bus.start_dump = 1'b0; bus.dump_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_dump_valid", bus.dump_valid, 1'b0);
    check("reset_err", bus.err_access, 1'b0);
    check("reset_rd_charge", bus.rd_charge, 0);
    check("reset_rd_echo", bus.rd_addr_echo, 0);
    check("reset_dump_addr", bus.dump_addr, 0);
    check("reset_dump_charge", bus.dump_charge, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Clear: busy for exactly 64 cycles, dump pulse ignored, access flagged
    bus.start_clear = 1'b1;
    tick();
    bus.start_clear = 1'b0;
    n = 0;
    while (bus.busy && n < 1000) begin
      n++;
      if (n == 5) begin
        bus.start_dump = 1'b1;
        bus.rd_valid   = 1'b1;
        bus.rd_addr    = corners(1, 1);
      end
      tick();
      bus.start_dump = 1'b0;
      bus.rd_valid   = 1'b0;
    end
    check("clear_busy_cycles", n, 64);
    check("clear_err_access", bus.err_access, 1'b1);
    repeat (3) tick();
    check("dump_ignored_busy", bus.busy, 1'b0);
    check("dump_ignored_valid", bus.dump_valid, 1'b0);

    // Dump after clear yields zeros
    pulse_dump();
    wait_dump_done(1'b0);

    // Corner read/write
    do_write(3, 5, {24'd40, 24'd30, 24'd20, 24'd10});
    do_read(3, 5);
    repeat (RL - 1) tick();
    check("corner_rd_charge", bus.rd_charge, {24'd40, 24'd30, 24'd20, 24'd10});
    check("corner_rd_echo", bus.rd_addr_echo, 32'h46453635);

    // Wrap at the grid edge
    do_write(15, 15, {24'd4, 24'd3, 24'd2, 24'd1});
    do_read(15, 15);
    repeat (RL - 1) tick();
    check("wrap_rd_charge", bus.rd_charge, {24'd4, 24'd3, 24'd2, 24'd1});
    check("wrap_rd_echo", bus.rd_addr_echo, 32'h000FF0FF);

    // Read-first hazard
    do_write(2, 2, {4{24'd7}});
    bus.wr_valid = 1'b1; bus.wr_addr = corners(2, 2); bus.wr_charge = {4{24'd9}};
    bus.rd_valid = 1'b1; bus.rd_addr = corners(2, 2);
    tick();
    bus.wr_valid = 1'b0;
    tick();
    bus.rd_valid = 1'b0;
    repeat (RL - 2) tick();
    check("hazard_same_cycle", bus.rd_charge[CW-1:0], 24'd7);
    tick();
    check("hazard_next_cycle", bus.rd_charge[CW-1:0], 24'd9);

    // Random scatter traffic
    for (int t = 0; t < 400; t++) begin
      bus.rd_valid  = 1'($urandom_range(0, 1));
      bus.rd_addr   = corners($urandom_range(0, 15), $urandom_range(0, 15));
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_addr   = corners($urandom_range(0, 15), $urandom_range(0, 15));
      bus.wr_charge = {CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom)};
      tick();
    end
    bus.rd_valid = 1'b0;
    bus.wr_valid = 1'b0;
    repeat (RL + 1) tick();

    // Dump with random backpressure, then a second dump
    fill_grid();
    pulse_dump();
    wait_dump_done(1'b1);
    pulse_dump();
    wait_dump_done(1'b1);

    // Reset mid-dump, then restart from address 0
    fill_grid();
    bus.dump_ready = 1'b1;
    pulse_dump();
    n = 0;
    while (dump_seen < 50 && n < 1000) begin
      tick();
      n++;
    end
    check("mid_dump_reached_50", dump_seen >= 50, 1'b1);
    rst = 1'b1;
    bus.dump_ready = 1'b0;
    tick();
    check("rst_mid_dump_valid", bus.dump_valid, 1'b0);
    check("rst_mid_dump_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();
    fill_grid();
    bus.dump_ready = 1'b1;
    pulse_dump();
    n = 0;
    while (!bus.dump_valid && n < 100) begin
      tick();
      n++;
    end
    check("restart_first_addr", bus.dump_addr, 0);
    wait_dump_done(1'b0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
